// File: rtl/cepstral_mac_if.sv
// Coefficient output stream of the cepstral MAC: AXI-Stream beat plus a per-beat saturation flag.
interface cepstral_mac_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [3:0]        tuser;
  logic              tsat;

  modport master (output tdata, output tvalid, output tlast, output tuser, output tsat, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, input tsat, output tready);
endinterface

// File: rtl/cepstral_mac.sv
// Thirteen parallel signed MACs over a frame of operands, then a serial drain of the
// scaled, saturated coefficients on the output stream.
module cepstral_mac #(
  parameter int DATA_W    = 16,
  parameter int N_COEF    = 13,
  parameter int FRAME_LEN = 256,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_to_mult_a,
  input  logic [DATA_W-1:0] data_to_mult_b0,
  input  logic [DATA_W-1:0] data_to_mult_b1,
  input  logic [DATA_W-1:0] data_to_mult_b2,
  input  logic [DATA_W-1:0] data_to_mult_b3,
  input  logic [DATA_W-1:0] data_to_mult_b4,
  input  logic [DATA_W-1:0] data_to_mult_b5,
  input  logic [DATA_W-1:0] data_to_mult_b6,
  input  logic [DATA_W-1:0] data_to_mult_b7,
  input  logic [DATA_W-1:0] data_to_mult_b8,
  input  logic [DATA_W-1:0] data_to_mult_b9,
  input  logic [DATA_W-1:0] data_to_mult_b10,
  input  logic [DATA_W-1:0] data_to_mult_b11,
  input  logic [DATA_W-1:0] data_to_mult_b12,
  input  logic              mult_valid,
  output logic              tready_out,
  cepstral_mac_if.master    m
);
  localparam int             CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [3:0]     IDX_LAST = 4'(N_COEF - 1);
  localparam int             PROD_W   = 2 * DATA_W;

  typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t                   state_r, state_nxt_s;
  logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
  logic [3:0]               idx_r, idx_nxt_s, idx_inc_s;
  logic                     tready_r, tready_nxt_s;
  logic                     valid_r, valid_nxt_s;
  logic [DATA_W-1:0]        data_r, data_nxt_s;
  logic [3:0]               user_r, user_nxt_s;
  logic                     last_r, last_nxt_s;
  logic                     sat_r, sat_nxt_s;
  logic [DATA_W:0]          beat_s;
  logic                     accept_s;
  logic [DATA_W-1:0]        b_s      [N_COEF];
  logic signed [PROD_W-1:0] prod_s   [N_COEF];
  logic signed [ACC_W-1:0]  acc_r    [N_COEF];
  logic signed [ACC_W-1:0]  acc_nxt_s[N_COEF];

  // Returns {saturated, value}: arithmetic shift, then clamp to the signed output range.
  function automatic logic [DATA_W:0] scale_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    logic [ACC_W-DATA_W:0]   hi;
    sh = acc >>> OUT_SHIFT;
    hi = sh[ACC_W-1:DATA_W-1];
    if ((hi == '0) || (hi == '1)) begin
      scale_sat = {1'b0, sh[DATA_W-1:0]};
    end else if (sh[ACC_W-1]) begin
      scale_sat = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      scale_sat = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  assign b_s[0]  = data_to_mult_b0;
  assign b_s[1]  = data_to_mult_b1;
  assign b_s[2]  = data_to_mult_b2;
  assign b_s[3]  = data_to_mult_b3;
  assign b_s[4]  = data_to_mult_b4;
  assign b_s[5]  = data_to_mult_b5;
  assign b_s[6]  = data_to_mult_b6;
  assign b_s[7]  = data_to_mult_b7;
  assign b_s[8]  = data_to_mult_b8;
  assign b_s[9]  = data_to_mult_b9;
  assign b_s[10] = data_to_mult_b10;
  assign b_s[11] = data_to_mult_b11;
  assign b_s[12] = data_to_mult_b12;

  assign accept_s  = mult_valid & tready_r & (state_r == ST_ACCUM);
  assign idx_inc_s = idx_r + 4'd1;

  // Full-width signed lane products.
  always_comb begin
    for (int k = 0; k < N_COEF; k++) begin
      prod_s[k] = $signed(data_to_mult_a) * $signed(b_s[k]);
    end
  end

  // Next-state, accumulator update and next output beat.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    idx_nxt_s    = idx_r;
    tready_nxt_s = tready_r;
    valid_nxt_s  = valid_r;
    data_nxt_s   = data_r;
    user_nxt_s   = user_r;
    last_nxt_s   = last_r;
    sat_nxt_s    = sat_r;
    beat_s       = '0;
    acc_nxt_s    = acc_r;
    case (state_r)
      ST_ACCUM: begin
        tready_nxt_s = 1'b1;
        if (accept_s) begin
          for (int k = 0; k < N_COEF; k++) begin
            acc_nxt_s[k] = acc_r[k] + {{(ACC_W-PROD_W){prod_s[k][PROD_W-1]}}, prod_s[k]};
          end
          if (cnt_r == CNT_LAST) begin
            // The first beat is taken from the updated accumulator so it appears with no bubble.
            beat_s       = scale_sat(acc_nxt_s[0]);
            cnt_nxt_s    = '0;
            state_nxt_s  = ST_DRAIN;
            tready_nxt_s = 1'b0;
            valid_nxt_s  = 1'b1;
            idx_nxt_s    = 4'd0;
            data_nxt_s   = beat_s[DATA_W-1:0];
            sat_nxt_s    = beat_s[DATA_W];
            user_nxt_s   = 4'd0;
            last_nxt_s   = (IDX_LAST == 4'd0);
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DRAIN: begin
        tready_nxt_s = 1'b0;
        if (valid_r && m.tready) begin
          if (idx_r == IDX_LAST) begin
            for (int k = 0; k < N_COEF; k++) begin
              acc_nxt_s[k] = '0;
            end
            state_nxt_s  = ST_ACCUM;
            tready_nxt_s = 1'b1;
            valid_nxt_s  = 1'b0;
            idx_nxt_s    = 4'd0;
            data_nxt_s   = '0;
            sat_nxt_s    = 1'b0;
            user_nxt_s   = 4'd0;
            last_nxt_s   = 1'b0;
          end else begin
            beat_s     = scale_sat(acc_r[idx_inc_s]);
            idx_nxt_s  = idx_inc_s;
            data_nxt_s = beat_s[DATA_W-1:0];
            sat_nxt_s  = beat_s[DATA_W];
            user_nxt_s = idx_inc_s;
            last_nxt_s = (idx_inc_s == IDX_LAST);
          end
        end else begin
          valid_nxt_s = valid_r;
        end
      end
      default: begin
        state_nxt_s  = ST_ACCUM;
        tready_nxt_s = 1'b0;
        valid_nxt_s  = 1'b0;
        data_nxt_s   = '0;
        sat_nxt_s    = 1'b0;
        user_nxt_s   = 4'd0;
        last_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, accumulator and registered output stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_ACCUM;
      cnt_r    <= '0;
      idx_r    <= 4'd0;
      tready_r <= 1'b0;
      valid_r  <= 1'b0;
      data_r   <= '0;
      user_r   <= 4'd0;
      last_r   <= 1'b0;
      sat_r    <= 1'b0;
      for (int k = 0; k < N_COEF; k++) begin
        acc_r[k] <= '0;
      end
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      idx_r    <= idx_nxt_s;
      tready_r <= tready_nxt_s;
      valid_r  <= valid_nxt_s;
      data_r   <= data_nxt_s;
      user_r   <= user_nxt_s;
      last_r   <= last_nxt_s;
      sat_r    <= sat_nxt_s;
      for (int k = 0; k < N_COEF; k++) begin
        acc_r[k] <= acc_nxt_s[k];
      end
    end
  end

  assign tready_out = tready_r;
  assign m.tvalid   = valid_r;
  assign m.tdata    = data_r;
  assign m.tuser    = user_r;
  assign m.tlast    = last_r;
  assign m.tsat     = sat_r;
endmodule
